// File: rtl/uart_tx_controller.sv
// uart_tx_controller: serialises start/data/even-parity/stop frames on
// baud-generator strobes and owns the generator's rate code.
module uart_tx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  output logic [2:0]           baud_select,
  input  logic [2:0]           cfg_baud,
  input  logic                 cfg_wr,
  output logic                 cfg_ERROR,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 TxD,
  output logic                 Tx_BUSY,
  output logic                 Tx_DONE
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q;
  logic [SW-1:0]        scnt_q;
  logic [BW-1:0]        bcnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 prev_se_q;
  logic [2:0]           baud_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cerr_q;

  logic strobe_d;
  logic bit_end_d;
  logic accept_d;
  logic abort_d;

  // Each level change of the generator output is one sample strobe.
  assign strobe_d  = sample_ENABLE ^ prev_se_q;
  assign bit_end_d = strobe_d && (scnt_q == S_LAST);
  assign accept_d  = Tx_WR && Tx_EN && !cfg_wr;
  assign abort_d   = (state_q != IDLE) && !Tx_EN;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      prev_se_q <= 1'b0;
      baud_q    <= 3'b000;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      prev_se_q <= sample_ENABLE;
      done_q    <= 1'b0;
      cerr_q    <= 1'b0;
      if (cfg_wr) begin
        if (state_q == IDLE) baud_q <= cfg_baud;
        else                 cerr_q <= 1'b1;
      end
      if (abort_d) begin
        state_q <= IDLE;
        scnt_q  <= '0;
        bcnt_q  <= '0;
        txd_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        if (strobe_d && state_q != IDLE) begin
          scnt_q <= bit_end_d ? '0 : scnt_q + SW'(1);
        end
        unique case (state_q)
          IDLE: begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            if (accept_d) begin
              state_q <= START;
              scnt_q  <= '0;
              shreg_q <= Tx_DATA;
              par_q   <= ^Tx_DATA;
              txd_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (bit_end_d) begin
              state_q <= DATA;
              bcnt_q  <= '0;
              txd_q   <= shreg_q[0];
            end
          end
          DATA: begin
            if (bit_end_d) begin
              if (bcnt_q == B_LAST) begin
                state_q <= PARITY;
                txd_q   <= par_q;
              end else begin
                bcnt_q  <= bcnt_q + BW'(1);
                shreg_q <= shreg_q >> 1;
                txd_q   <= shreg_q[1];
              end
            end
          end
          PARITY: begin
            if (bit_end_d) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end
          end
          STOP: begin
            if (bit_end_d) begin
              state_q <= IDLE;
              bcnt_q  <= '0;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign baud_select = baud_q;
  assign cfg_ERROR   = cerr_q;
  assign TxD         = txd_q;
  assign Tx_BUSY     = busy_q;
  assign Tx_DONE     = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: table vectors, corner sequences and random
// traffic checked cycle by cycle against a frame-level model.
module tb_uart_tx_controller;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int NB = DB + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b0;
  logic          se       = 1'b0;
  logic          cfg_wr   = 1'b0;
  logic          tx_en    = 1'b1;
  logic          tx_wr    = 1'b0;
  logic [2:0]    cfg_baud = 3'b000;
  logic [DB-1:0] tx_data  = '0;
  logic [2:0]    baud_select;
  logic          txd;
  logic          busy;
  logic          done;
  logic          cerr;

  uart_tx_controller #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_ENABLE(se),
    .baud_select  (baud_select),
    .cfg_baud     (cfg_baud),
    .cfg_wr       (cfg_wr),
    .cfg_ERROR    (cerr),
    .Tx_EN        (tx_en),
    .Tx_WR        (tx_wr),
    .Tx_DATA      (tx_data),
    .TxD          (txd),
    .Tx_BUSY      (busy),
    .Tx_DONE      (done)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // frame-level reference: strobes counted since acceptance
  logic       m_busy, m_done, m_err, m_txd, m_se;
  logic [2:0] m_baud;
  int         m_k;
  logic       m_bits[NB];
  logic       cap[NB];

  int se_per  = 1;
  int se_cnt  = 0;
  bit se_rand = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic stb;
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_se   = 1'b0;
      m_baud = 3'b000;
      m_k    = 0;
    end else begin
      stb    = (se != m_se);
      m_se   = se;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (cfg_wr) begin
        if (!m_busy) m_baud = cfg_baud;
        else         m_err  = 1'b1;
      end
      if (m_busy) begin
        if (!tx_en) m_busy = 1'b0;
        else begin
          if (stb) m_k++;
          if (m_k == NB * OS) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (tx_wr && tx_en && !cfg_wr) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) m_bits[i+1] = tx_data[i];
        m_bits[DB+1] = ^tx_data;
        m_bits[DB+2] = 1'b1;
      end
    end
    m_txd = m_busy ? m_bits[m_k / OS] : 1'b1;
  endtask

  task automatic cycle();
    if (se_rand) begin
      if ($urandom_range(1, 0) == 1) se = ~se;
    end else begin
      se_cnt++;
      if (se_cnt >= se_per) begin
        se_cnt = 0;
        se = ~se;
      end
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("txd", 32'(txd), 32'(m_txd));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("cfg_err", 32'(cerr), 32'(m_err));
    chk("baud", 32'(baud_select), 32'(m_baud));
    if (m_busy && (m_k % OS) == OS / 2) cap[m_k / OS] = txd;
  endtask

  task automatic start_frame(logic [DB-1:0] d, bit align);
    if (align) begin
      while (se_cnt != se_per - 1) cycle();
    end
    tx_data = d;
    tx_wr   = 1'b1;
    cycle();
    tx_wr   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int t0;
    t0  = cyc;
    lat = -1;
    for (int c = 0; c < 4000; c++) begin
      cycle();
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_to_bit(int idx);
    for (int c = 0; c < 4000; c++) begin
      if (m_busy && (m_k / OS) >= idx) return;
      cycle();
    end
    chk("bit_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         per;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    int npulse;
    logic [7:0] rx;

    tbl[0] = '{8'hA5, 1'b0, 2};
    tbl[1] = '{8'h07, 1'b1, 2};
    tbl[2] = '{8'hFF, 1'b0, 1};
    tbl[3] = '{8'h00, 1'b0, 3};
    tbl[4] = '{8'h80, 1'b1, 1};
    tbl[5] = '{8'h3D, 1'b1, 2};

    se_per = 1;
    reset  = 1'b0;
    repeat (3) cycle();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_baud", 32'(baud_select), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (4) cycle();

    for (int v = 0; v < 6; v++) begin
      se_per = tbl[v].per;
      se_cnt = 0;
      for (int i = 0; i < NB; i++) cap[i] = 1'bx;
      start_frame(tbl[v].data, 1'b1);
      wait_done(lat);
      chk("done_lat", 32'(lat), 32'(NB * OS * tbl[v].per));
      for (int i = 0; i < DB; i++) rx[i] = cap[i+1];
      chk("start_bit", 32'(cap[0]), 32'd0);
      chk("data_bits", 32'(rx), 32'(tbl[v].data));
      chk("parity", 32'(cap[DB+1]), 32'(tbl[v].par));
      chk("stop_bit", 32'(cap[DB+2]), 32'd1);
      repeat (3) cycle();
    end

    se_per = 2;
    start_frame(8'h3C, 1'b0);
    repeat (50) cycle();
    cfg_baud = 3'b101;
    cfg_wr   = 1'b1;
    cycle();
    cfg_wr   = 1'b0;
    chk("busy_cfg_err", 32'(cerr), 32'd1);
    chk("busy_cfg_baud", 32'(baud_select), 32'd0);
    cycle();
    chk("cfg_err_len", 32'(cerr), 32'd0);
    wait_done(lat);
    cycle();
    cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    chk("idle_cfg_baud", 32'(baud_select), 32'd5);

    cfg_baud = 3'b011;
    cfg_wr   = 1'b1;
    tx_wr    = 1'b1;
    tx_data  = 8'hFF;
    cycle();
    cfg_wr   = 1'b0;
    tx_wr    = 1'b0;
    chk("coll_baud", 32'(baud_select), 32'd3);
    chk("coll_busy", 32'(busy), 32'd0);
    cycle();
    chk("coll_busy2", 32'(busy), 32'd0);

    start_frame(8'hC3, 1'b0);
    wait_done(lat);
    chk("b2b_idle_txd", 32'(txd), 32'd1);
    start_frame(8'h5A, 1'b0);
    chk("b2b_txd", 32'(txd), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);

    start_frame(8'h00, 1'b0);
    run_to_bit(4);
    tx_en = 1'b0;
    cycle();
    tx_en = 1'b1;
    chk("abort_txd", 32'(txd), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    npulse = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (done === 1'b1) npulse++;
    end
    chk("abort_no_done", 32'(npulse), 32'd0);

    start_frame(8'h00, 1'b0);
    run_to_bit(DB + 1);
    chk("par_txd", 32'(txd), 32'd0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("rst_mid_txd", 32'(txd), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_baud", 32'(baud_select), 32'd0);
    repeat (5) cycle();

    se_rand = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      tx_wr    = ($urandom_range(7, 0) == 0);
      tx_data  = DB'($urandom);
      cfg_wr   = ($urandom_range(63, 0) == 0);
      cfg_baud = 3'($urandom);
      tx_en    = ($urandom_range(499, 0) != 0);
      cycle();
    end
    tx_wr  = 1'b0;
    cfg_wr = 1'b0;
    tx_en  = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_controller.md
# uart_tx_controller

Sequences UART transmit frames on the strobes produced by the baud generator. It owns the generator's `baud_select` configuration and allows rate changes only while the line is idle. It converts each change of `sample_ENABLE` into one sample strobe and counts `OVERSAMPLE` strobes per bit. It serialises start, data (LSB first), even-parity and stop bits onto `TxD`.

## Interface
- `OVERSAMPLE`, default 16: sample strobes per transmitted bit; valid range 2..64.
- `DATA_BITS`, default 8: data bits per frame; valid range 5..8.

- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`, and `reset`=0 forces the reset state.
- `sample_ENABLE`, in, 1: toggling output of the baud generator. Every change of level is one sample strobe.
- `baud_select`, out, 3: rate code driven to the baud generator.
- `cfg_baud`, in, 3: new rate code.
- `cfg_wr`, in, 1: single-cycle request to load `cfg_baud`.
- `cfg_ERROR`, out, 1: one-cycle pulse when `cfg_wr` is rejected.
- `Tx_EN`, in, 1: transmitter enable.
- `Tx_WR`, in, 1: single-cycle write of `Tx_DATA`.
- `Tx_DATA`, in, `DATA_BITS`: byte to send.
- `TxD`, out, 1: serial line, idle high.
- `Tx_BUSY`, out, 1: high while a frame is in progress.
- `Tx_DONE`, out, 1: one-cycle pulse after the stop bit completes.

## Operation
- Strobe detection:
  - `prev_se` register, reset value 0.
  - `strobe` = `sample_ENABLE` XOR `prev_se`.
  - `prev_se` <= `sample_ENABLE` every cycle, including while idle.
- States: IDLE, START, DATA, PARITY, STOP.
- `scnt` counts 0..`OVERSAMPLE`-1. It increments only on `strobe` and is cleared on every state entry.
- `bcnt` counts 0..`DATA_BITS`-1.
- Bit end = `strobe` AND `scnt`==`OVERSAMPLE`-1. On bit end:
  - START -> DATA with `bcnt`=0.
  - DATA: `bcnt`++, shifting the data register right. When `bcnt`==`DATA_BITS`-1, go to PARITY.
  - PARITY -> STOP.
  - STOP -> IDLE.
- `TxD` is registered and driven per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: XOR of the latched data, so parity is even.
  - STOP: 1.
- Frame acceptance (IDLE only):
  - `Tx_WR`=1 AND `Tx_EN`=1 AND `cfg_wr`=0 latches `Tx_DATA` and moves the block to START.
  - Parity is computed from the latched copy, not from the live `Tx_DATA` input.
  - `Tx_WR` outside IDLE, or with `Tx_EN`=0, is ignored. There is no queueing.
- Config:
  - `cfg_wr` in IDLE: `baud_select` <= `cfg_baud`.
  - `cfg_wr` in any other state: `baud_select` is unchanged and `cfg_ERROR` pulses.
  - `cfg_wr` and `Tx_WR` in the same IDLE cycle: the config load wins and `Tx_WR` is dropped.
- `Tx_EN` falling in any non-IDLE state aborts the frame:
  - Next cycle: IDLE, `TxD`=1, `Tx_BUSY`=0.
  - No `Tx_DONE` pulse.
- Reset values:
  - `baud_select`=3'b000, `TxD`=1, `Tx_BUSY`=0, `Tx_DONE`=0, `cfg_ERROR`=0.
  - State IDLE, `scnt`=`bcnt`=0, `prev_se`=0.
  - Reset mid-frame is immediate on that edge. No stop bit is emitted.

## Timing
- Accept at edge n: from n+1, `TxD`=0 and `Tx_BUSY`=1.
- A strobe in the accept cycle is not counted.
- Each bit lasts exactly `OVERSAMPLE` strobes. Frame length = (`DATA_BITS`+3)·`OVERSAMPLE` strobes.
- On the final STOP bit end (edge m), from m+1:
  - State IDLE, `Tx_BUSY`=0, `TxD`=1.
  - `Tx_DONE`=1 for exactly one cycle.
- Back-to-back: `Tx_WR` in the `Tx_DONE` cycle is accepted. `TxD` then goes 0 one cycle later, giving one clock of idle-high minimum.
- `baud_select` changes one cycle after an accepted `cfg_wr`.
- `cfg_ERROR` asserts one cycle after a rejected `cfg_wr` and lasts one cycle.
- `Tx_BUSY` = (state != IDLE), registered.

## Test plan
- Reset: hold `reset`=0 for 3 clocks with `sample_ENABLE` toggling, then release. Required:
  - `TxD`=1, `baud_select`=000, `Tx_BUSY`=0.
  - `Tx_DONE` and `cfg_ERROR` never pulse.
- Single frame: `sample_ENABLE` toggles every 2 clocks, `OVERSAMPLE`=16, `Tx_DATA`=8'hA5. Required:
  - `TxD` = 0,1,0,1,0,0,1,0,1,0,1, each held 32 clocks.
  - `Tx_DONE` pulses 352 clocks after `TxD` falls.
- Parity: `Tx_DATA`=8'h07. Required: data bits 1,1,1,0,0,0,0,0, then parity 1.
- Config while busy: `cfg_wr` with `cfg_baud`=3'b101 mid-frame. Required:
  - `cfg_ERROR` pulses 1 cycle and `baud_select` stays 000.
  - The same write issued in IDLE gives `baud_select`=101 the next cycle.
- Collisions:
  - `Tx_WR` together with `cfg_wr` in IDLE: `baud_select` updates, `Tx_BUSY` stays 0.
  - `Tx_WR` in the `Tx_DONE` cycle: second frame starts and `TxD`=0 one cycle later.
- Abort and reset mid-frame:
  - Drop `Tx_EN` during DATA bit 3: next cycle `TxD`=1 and `Tx_BUSY`=0, no `Tx_DONE`.
  - Assert `reset`=0 during PARITY: reset values on the next edge.
